// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared types and widths for the FPGA-Hero scoring path
package fpga_hero_pkg;

    localparam int SCORE_W = 20;
    localparam int PTS_W   = 10;
    localparam int COMBO_W = 10;
    localparam int MULT_W  = 3;

    typedef enum logic [1:0] {
        RES_MISS    = 2'b00,
        RES_GOOD    = 2'b01,
        RES_PERFECT = 2'b10,
        RES_RSVD    = 2'b11
    } note_result_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAYING = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - judgement-event inputs and scoreboard outputs of score_keeper
interface score_keeper_if;
    import fpga_hero_pkg::*;

    logic               start;
    logic               song_end;
    logic               note_event;
    logic [1:0]         note_result;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [COMBO_W-1:0] max_combo;
    logic [MULT_W-1:0]  multiplier;
    logic               playing;

    modport master (
        output start, song_end, note_event, note_result,
        input  score, combo, max_combo, multiplier, playing
    );

    modport slave (
        input  start, song_end, note_event, note_result,
        output score, combo, max_combo, multiplier, playing
    );

endinterface

// File: rtl/score_sat_add.sv
// rtl/score_sat_add.sv - registered score accumulator that clamps at the display maximum
module score_sat_add
    import fpga_hero_pkg::*;
#(
    parameter int unsigned MAX_SCORE = 999999
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               valid,
    input  logic [PTS_W-1:0]   pts,
    output logic [SCORE_W-1:0] score
);

    localparam logic [SCORE_W:0] SAT = MAX_SCORE[SCORE_W:0];

    // One spare bit so the sum can be compared against the ceiling before it wraps.
    logic [SCORE_W:0] sum;

    always_comb begin
        sum = {1'b0, score} + {{(SCORE_W+1-PTS_W){1'b0}}, pts};
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            score <= '0;
        end else if (valid) begin
            score <= (sum > SAT) ? SAT[SCORE_W-1:0] : sum[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - turns note judgements into score, combo and multiplier
module score_keeper
    import fpga_hero_pkg::*;
#(
    parameter int unsigned PERFECT_PTS = 100,
    parameter int unsigned GOOD_PTS    = 50,
    parameter int unsigned COMBO_STEP  = 10,
    parameter int unsigned MAX_MULT    = 4,
    parameter int unsigned MAX_SCORE   = 999999,
    parameter int unsigned MAX_COMBO   = 999
) (
    input  logic        clock,
    input  logic        reset,
    score_keeper_if.slave sk
);

    localparam logic [PTS_W-1:0]   PERFECT_B = PERFECT_PTS[PTS_W-1:0];
    localparam logic [PTS_W-1:0]   GOOD_B    = GOOD_PTS[PTS_W-1:0];
    localparam logic [COMBO_W-1:0] STEP_C    = COMBO_STEP[COMBO_W-1:0];
    localparam logic [COMBO_W-1:0] MAXC      = MAX_COMBO[COMBO_W-1:0];
    localparam logic [COMBO_W-1:0] MULT_TOP  = COMBO_W'(MAX_MULT - 1);
    localparam logic [MULT_W-1:0]  MAXM      = MAX_MULT[MULT_W-1:0];

    state_t             state;
    logic               playing_q;
    logic [COMBO_W-1:0] combo_q, max_q;
    logic [MULT_W-1:0]  mult_q;
    logic [PTS_W-1:0]   pts_q;
    logic               pts_v;
    logic [SCORE_W-1:0] score_q;

    logic               accept, is_hit, clear;
    logic [PTS_W-1:0]   base, pts_n;
    logic [COMBO_W-1:0] combo_n, max_n, step;
    logic [MULT_W-1:0]  mult_n;

    always_comb begin
        accept  = sk.note_event && (state == ST_PLAYING);
        clear   = sk.start && (state != ST_PLAYING);
        is_hit  = (sk.note_result == RES_GOOD) || (sk.note_result == RES_PERFECT);
        base    = (sk.note_result == RES_PERFECT) ? PERFECT_B :
                  (sk.note_result == RES_GOOD)    ? GOOD_B    : '0;
        // Points use the multiplier in force before this note updates it.
        pts_n   = base * PTS_W'(mult_q);
        combo_n = !is_hit ? '0 : (combo_q >= MAXC) ? MAXC : combo_q + COMBO_W'(1);
        max_n   = (combo_n > max_q) ? combo_n : max_q;
        step    = combo_n / STEP_C;
        mult_n  = !is_hit ? MULT_W'(1) :
                  (step >= MULT_TOP) ? MAXM : step[MULT_W-1:0] + MULT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            playing_q <= 1'b0;
            combo_q   <= '0;
            max_q     <= '0;
            mult_q    <= MULT_W'(1);
            pts_q     <= '0;
            pts_v     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (sk.start) begin
                    state     <= ST_PLAYING;
                    playing_q <= 1'b1;
                end
                ST_PLAYING: if (sk.song_end) begin
                    state     <= ST_DONE;
                    playing_q <= 1'b0;
                end
                ST_DONE: if (sk.start) begin
                    state     <= ST_PLAYING;
                    playing_q <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    playing_q <= 1'b0;
                end
            endcase

            if (clear) begin
                combo_q <= '0;
                max_q   <= '0;
                mult_q  <= MULT_W'(1);
                pts_v   <= 1'b0;
            end else begin
                pts_v <= accept;
                pts_q <= pts_n;
                if (accept) begin
                    combo_q <= combo_n;
                    max_q   <= max_n;
                    mult_q  <= mult_n;
                end
            end
        end
    end

    score_sat_add #(
        .MAX_SCORE (MAX_SCORE)
    ) u_sat_add (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .valid (pts_v),
        .pts   (pts_q),
        .score (score_q)
    );

    assign sk.score      = score_q;
    assign sk.combo      = combo_q;
    assign sk.max_combo  = max_q;
    assign sk.multiplier = mult_q;
    assign sk.playing    = playing_q;

endmodule
